// File: rtl/peripheral_control_movimiento_n.sv
// N-axis motion-control peripheral: per-axis register bank plus
// closed-loop direction FSM with deadband, brake dead-time and arrived flag.
module peripheral_control_movimiento_n #(
  parameter int N_AXES = 2,
  parameter int DW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     d_in,
  input  logic              cs,
  input  logic [5:0]        addr,
  input  logic              rd,
  input  logic              wr,
  output logic [DW-1:0]     d_out,
  output logic [N_AXES-1:0] mot_pos,
  output logic [N_AXES-1:0] mot_neg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    POS   = 3'd2,
    NEG   = 3'd3,
    BRAKE = 3'd4
  } st_e;

  localparam int EW = DW + 2;

  logic [2:0]    ax;
  logic [2:0]    rg;
  logic [DW-1:0] rv_a [N_AXES];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] d_out_q;

  assign ax = addr[5:3];
  assign rg = addr[2:0];

  for (genvar gi = 0; gi < N_AXES; gi++) begin : g_axis
    logic [DW-1:0] ctrl_q, sa_q, sb_q, tgt_q, act_q, db_q, dt_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] stat;
    logic [DW-1:0] rv;
    st_e           st_q;
    logic          arr_q, mp_q, mn_q;
    logic          sel, wr_en, rd_stat, en;
    logic signed [EW-1:0] err, dbx;
    logic          up, dn, inb;

    assign sel     = cs && (ax == 3'(gi));
    assign wr_en   = sel && wr;
    assign rd_stat = sel && rd && (rg == 3'd7);
    assign en      = ctrl_q[0];

    // Widened by two bits so neither error nor -deadband can overflow
    assign err = ctrl_q[1]
      ? $signed({{2{tgt_q[DW-1]}}, tgt_q}) - $signed({{2{act_q[DW-1]}}, act_q})
      : $signed({2'b00, sa_q}) - $signed({2'b00, sb_q});
    assign dbx = $signed({2'b00, db_q});
    assign up  = err > dbx;
    assign dn  = err < -dbx;
    assign inb = !up && !dn;

    assign stat = {{(DW-6){1'b0}}, arr_q, mn_q, mp_q, st_q};

    always_ff @(posedge clk) begin
      if (rst) begin
        ctrl_q <= '0;
        sa_q   <= '0;
        sb_q   <= '0;
        tgt_q  <= '0;
        act_q  <= '0;
        db_q   <= '0;
        dt_q   <= '0;
      end else if (wr_en) begin
        case (rg)
          3'd0:    ctrl_q <= d_in;
          3'd1:    sa_q   <= d_in;
          3'd2:    sb_q   <= d_in;
          3'd3:    tgt_q  <= d_in;
          3'd4:    act_q  <= d_in;
          3'd5:    db_q   <= d_in;
          3'd6:    dt_q   <= d_in;
          default: ;
        endcase
      end
    end

    // A set of arrived in the same cycle as a status read wins (later NBA)
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        arr_q <= 1'b0;
        mp_q  <= 1'b0;
        mn_q  <= 1'b0;
      end else begin
        if (rd_stat) arr_q <= 1'b0;
        mp_q <= 1'b0;
        mn_q <= 1'b0;
        if (!en) begin
          st_q  <= IDLE;
          cnt_q <= '0;
        end else begin
          case (st_q)
            IDLE: st_q <= HOLD;
            HOLD: begin
              if (up) begin
                st_q <= POS;
                mp_q <= 1'b1;
              end else if (dn) begin
                st_q <= NEG;
                mn_q <= 1'b1;
              end
            end
            POS: begin
              if (inb) begin
                st_q  <= HOLD;
                arr_q <= 1'b1;
              end else if (dn) begin
                st_q  <= BRAKE;
                cnt_q <= dt_q;
              end else begin
                mp_q <= 1'b1;
              end
            end
            NEG: begin
              if (inb) begin
                st_q  <= HOLD;
                arr_q <= 1'b1;
              end else if (up) begin
                st_q  <= BRAKE;
                cnt_q <= dt_q;
              end else begin
                mn_q <= 1'b1;
              end
            end
            BRAKE: begin
              if (cnt_q == '0) st_q <= HOLD;
              else cnt_q <= cnt_q - 1'b1;
            end
            default: st_q <= IDLE;
          endcase
        end
      end
    end

    always_comb begin
      rv = '0;
      case (rg)
        3'd0:    rv = ctrl_q;
        3'd1:    rv = sa_q;
        3'd2:    rv = sb_q;
        3'd3:    rv = tgt_q;
        3'd4:    rv = act_q;
        3'd5:    rv = db_q;
        3'd6:    rv = dt_q;
        default: rv = stat;
      endcase
    end

    assign rv_a[gi]    = rv;
    assign mot_pos[gi] = mp_q;
    assign mot_neg[gi] = mn_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < N_AXES; i++) begin
      if (ax == 3'(i)) rdata_d = rv_a[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) d_out_q <= '0;
    else if (cs && rd) d_out_q <= rdata_d;
    else d_out_q <= '0;
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_control_movimiento_n.sv
// Directed bench for peripheral_control_movimiento_n (N_AXES=2, DW=16).
// Inputs change #1 after posedge; outputs sampled #1 after posedge.
module tb_peripheral_control_movimiento_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [5:0]  addr;
  logic [15:0] d_out;
  logic [1:0]  mot_pos, mot_neg;

  int n_cmp = 0;
  int n_bad = 0;

  peripheral_control_movimiento_n #(.N_AXES(2), .DW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .cs      (cs),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .d_out   (d_out),
    .mot_pos (mot_pos),
    .mot_neg (mot_neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [5:0] a, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  logic [15:0] v;

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dout", d_out, 0);
    check("rst_pos", mot_pos, 0);
    check("rst_neg", mot_neg, 0);
    rd_reg(6'h07, v);
    check("rst_stat0", v, 0);

    wr_reg(6'h0B, 16'h1234);
    rd_reg(6'h0B, v);
    check("rb_tgt1", v, 16'h1234);
    tick();
    check("dout_idle", d_out, 0);
    wr_reg(6'h3B, 16'h5555);
    rd_reg(6'h3F, v);
    check("rd_bad_axis", v, 0);
    rd_reg(6'h3B, v);
    check("wr_bad_axis", v, 0);

    // Manual approach on axis 0
    wr_reg(6'h05, 16'd2);
    wr_reg(6'h03, 16'd100);
    wr_reg(6'h04, 16'd0);
    wr_reg(6'h00, 16'h0003);
    tick();
    tick();
    check("man_pos", mot_pos, 2'b01);
    rd_reg(6'h07, v);
    check("man_stat_pos", v, 16'h000A);
    wr_reg(6'h04, 16'd99);
    tick();
    check("man_arr_pos", mot_pos, 0);
    rd_reg(6'h07, v);
    check("arr_rd1", v, 16'h0021);
    rd_reg(6'h07, v);
    check("arr_rd2", v, 16'h0001);

    // Reversal with dead time 3
    wr_reg(6'h04, 16'd0);
    wr_reg(6'h06, 16'd3);
    check("rev_pos", mot_pos, 2'b01);
    wr_reg(6'h04, 16'd200);
    rd_reg(6'h07, v);
    check("rev_stat_pos", v, 16'h000A);
    for (int i = 0; i < 4; i++) begin
      rd_reg(6'h07, v);
      check($sformatf("brake%0d", i), v, 16'h0004);
      check($sformatf("brake_out%0d", i), {mot_pos, mot_neg}, 0);
    end
    rd_reg(6'h07, v);
    check("rev_hold", v, 16'h0001);
    check("rev_neg", mot_neg, 2'b01);
    rd_reg(6'h07, v);
    check("rev_stat_neg", v, 16'h0013);

    // Disable mid-move
    wr_reg(6'h00, 16'h0000);
    check("dis_still_neg", mot_neg, 2'b01);
    tick();
    check("dis_neg", mot_neg, 0);
    rd_reg(6'h07, v);
    check("dis_stat", v, 0);

    // Simultaneous rd and wr: old value returned, write lands
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 6'h03; d_in = 16'h0055;
    tick();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check("rw_old", d_out, 16'd100);
    rd_reg(6'h03, v);
    check("rw_new", v, 16'h0055);

    // Auto tracking on axis 1
    wr_reg(6'h0D, 16'd10);
    wr_reg(6'h09, 16'd500);
    wr_reg(6'h0A, 16'd495);
    wr_reg(6'h08, 16'h0001);
    tick();
    tick();
    rd_reg(6'h0F, v);
    check("auto_hold", v, 16'h0001);
    check("auto_hold_out", mot_pos, 0);
    wr_reg(6'h0A, 16'd480);
    tick();
    check("auto_pos", mot_pos, 2'b10);
    wr_reg(6'h0A, 16'd500);
    tick();
    check("auto_back", mot_pos, 0);
    wr_reg(6'h09, 16'hFFFF);
    wr_reg(6'h0A, 16'h0000);
    tick();
    tick();
    check("auto_nowrap_pos", mot_pos, 2'b10);
    check("auto_nowrap_neg", mot_neg, 0);

    // Reset mid-move
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_pos", mot_pos, 0);
    check("rst2_neg", mot_neg, 0);
    rd_reg(6'h07, v);
    check("rst2_stat0", v, 0);
    rd_reg(6'h0F, v);
    check("rst2_stat1", v, 0);
    rd_reg(6'h0B, v);
    check("rst2_tgt1", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/peripheral_control_movimiento_n.md
Name: peripheral_control_movimiento_n

Overview:
Parametrised N-axis successor to the two-axis (theta/phi) motion-control peripheral on the J1 I/O bus. Each axis has its own register bank and closed-loop direction controller. In auto mode an axis tracks a sensor pair; in manual mode it drives actual position toward a target. Each axis adds a deadband, a reversal dead-time state and a sticky "arrived" flag, none of which the previous block has.

Parameters:
N_AXES, 2, number of axes, legal range 1..8
DW, 16, register/data width; all per-axis registers are DW bits

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
d_in  input  DW  CPU write data
cs  input  1  peripheral chip select
addr  input  6  word address {axis[5:3], reg[2:0]}
rd  input  1  read strobe
wr  input  1  write strobe
d_out  output  DW  registered read data
mot_pos  output  N_AXES  per-axis positive-direction drive
mot_neg  output  N_AXES  per-axis negative-direction drive

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). All state updates on the posedge of clk.
- Reset: all registers 0, every axis in IDLE, mot_pos=mot_neg=0, d_out=0.
- Per-axis register map, selected by reg[2:0]:
  - 0 CTRL: bit0 enable; bit1 mode (0 = auto, 1 = manual); other bits read back as written.
  - 1 SENS_A: unsigned.
  - 2 SENS_B: unsigned.
  - 3 TARGET: signed.
  - 4 ACTUAL: signed.
  - 5 DEADBAND: unsigned.
  - 6 DEAD_TIME: unsigned.
  - 7 STATUS: read-only. [2:0] state, [3] mot_pos, [4] mot_neg, [5] arrived, rest 0.
- Write: when cs && wr, the addressed register takes d_in at the edge.
  - Writes to STATUS are ignored.
  - Writes with axis >= N_AXES are ignored.
- Read: when cs && rd, d_out takes the addressed register at the edge (1-cycle latency); otherwise d_out <= 0.
  - axis >= N_AXES reads 0.
  - rd takes priority in d_out selection if wr is also asserted; the write still occurs.
- Error, 17-bit signed:
  - Auto mode: err = zext(SENS_A) - zext(SENS_B).
  - Manual mode: err = sext(TARGET) - sext(ACTUAL).
  - Evaluated combinationally from current register values.
  - Band test: in-band when -DEADBAND <= err <= DEADBAND, with DEADBAND zero-extended.
- Per-axis FSM (3-bit encoding IDLE=0, HOLD=1, POS=2, NEG=3, BRAKE=4):
  - enable=0: go to IDLE from any state at the next edge; counter cleared.
  - IDLE & enable: go to HOLD.
  - HOLD: err > DEADBAND -> POS; err < -DEADBAND -> NEG; else stay.
  - POS: in-band -> HOLD and set arrived; err < -DEADBAND (overshoot) -> BRAKE and load cnt = DEAD_TIME; else stay.
  - NEG: mirror of POS.
  - BRAKE: if cnt == 0 -> HOLD, else cnt <= cnt-1. Total BRAKE duration is DEAD_TIME+1 cycles. Arrived is not set on BRAKE exit.
  - Encodings 5..7 are illegal and go to IDLE.
- Outputs are Moore and registered:
  - mot_pos[i] = (state==POS); mot_neg[i] = (state==NEG).
  - Never both high.
  - Both low in IDLE, HOLD and BRAKE.
- Latency: a register write at edge k is reflected in state and outputs at edge k+1.
- Mode or register change mid-move: re-evaluated on the next edge under the normal transition rules, with no extra state.
- arrived: sticky. Cleared by a read of that axis's STATUS at the read edge. A set in the same cycle as the clearing read wins (stays 1). The read returns the pre-clear value.
- rst mid-move: outputs low after the reset edge and all registers cleared.

Test Plan:
- Reset/readback: assert rst 1 cycle; write axis1 TARGET=0x1234; read addr 0x0B -> d_out=0x1234 one cycle after rd; read addr 0x3F with N_AXES=2 -> 0.
- Manual approach: axis0 CTRL=0x3, DEADBAND=2, TARGET=100, ACTUAL=0 -> HOLD then POS, mot_pos[0]=1. Write ACTUAL=99 -> next edge HOLD, mot_pos[0]=0, STATUS=0x21.
- Arrived clear: read STATUS (0x07) twice -> 0x21, then 0x01.
- Reversal dead time: axis0 in POS, DEAD_TIME=3, write ACTUAL=200 -> BRAKE with both outputs low for exactly 4 cycles, then HOLD, then NEG, mot_neg[0]=1, arrived=0.
- Auto tracking: axis1 CTRL=0x1, DEADBAND=10, SENS_A=500, SENS_B=495 -> stays HOLD. SENS_B=480 -> POS. SENS_A=0xFFFF, SENS_B=0 -> POS (unsigned, no wrap).
- Disable/reset mid-move: CTRL=0 while in NEG -> IDLE and outputs low next edge. Repeat with rst -> all STATUS reads 0.
